// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory pipeline stage: memory operation
// encoding, access-size constants, the writeback-bound record and small
// decode helpers used by both the stage FSM and the alignment logic.
package memory_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LD   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_LHU  = 4'd6,
        MEM_LWU  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SD   = 4'd11
    } mem_op_t;

    // log2 of the access size in bytes
    localparam logic [2:0] MSIZE_B = 3'd0;
    localparam logic [2:0] MSIZE_H = 3'd1;
    localparam logic [2:0] MSIZE_W = 3'd2;
    localparam logic [2:0] MSIZE_D = 3'd3;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  dst;
        logic        wen;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

    // True for every encoding that touches memory; unused encodings behave
    // like MEM_NONE so a corrupted opcode never issues a bus access.
    function automatic logic memop_is_mem(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LD,
            MEM_LBU, MEM_LHU, MEM_LWU,
            MEM_SB, MEM_SH, MEM_SW, MEM_SD: memop_is_mem = 1'b1;
            default:                        memop_is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic memop_is_store(input mem_op_t op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW, MEM_SD: memop_is_store = 1'b1;
            default:                        memop_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] memop_size(input mem_op_t op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: memop_size = MSIZE_H;
            MEM_LW, MEM_LWU, MEM_SW: memop_size = MSIZE_W;
            MEM_LD, MEM_SD:          memop_size = MSIZE_D;
            default:                 memop_size = MSIZE_B;
        endcase
    endfunction

    // Natural alignment check on the low address bits
    function automatic logic memop_misaligned(input mem_op_t op, input logic [2:0] offset);
        case (memop_size(op))
            MSIZE_H: memop_misaligned = offset[0];
            MSIZE_W: memop_misaligned = (offset[1:0] != 2'd0);
            MSIZE_D: memop_misaligned = (offset != 3'd0);
            default: memop_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane alignment for the memory stage.
// Ports:
//   st_size/st_offset/st_data -> st_strobe/st_wdata : store lane placement
//   ld_op/ld_offset/ld_data   -> ld_value           : load extraction and
//                                                      sign/zero extension
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [2:0]  st_offset,
    input  logic [63:0] st_data,
    input  logic [3:0]  ld_op,
    input  logic [2:0]  ld_offset,
    input  logic [63:0] ld_data,
    output logic [7:0]  st_strobe,
    output logic [63:0] st_wdata,
    output logic [63:0] ld_value
);

    logic [7:0]  mask_s;
    logic [63:0] raw_s;

    // Store side: byte-enable mask and data shifted onto their lanes
    always_comb begin
        case (st_size)
            MSIZE_B: mask_s = 8'h01;
            MSIZE_H: mask_s = 8'h03;
            MSIZE_W: mask_s = 8'h0F;
            MSIZE_D: mask_s = 8'hFF;
            default: mask_s = 8'h01;
        endcase
        st_strobe = mask_s << st_offset;
        st_wdata  = st_data << {st_offset, 3'b000};
    end

    // Load side: bring the addressed bytes to bit 0, then extend by kind
    always_comb begin
        raw_s = ld_data >> {ld_offset, 3'b000};
        case (mem_op_t'(ld_op))
            MEM_LB:  ld_value = {{56{raw_s[7]}},  raw_s[7:0]};
            MEM_LH:  ld_value = {{48{raw_s[15]}}, raw_s[15:0]};
            MEM_LW:  ld_value = {{32{raw_s[31]}}, raw_s[31:0]};
            MEM_LBU: ld_value = {56'd0, raw_s[7:0]};
            MEM_LHU: ld_value = {48'd0, raw_s[15:0]};
            MEM_LWU: ld_value = {32'd0, raw_s[31:0]};
            default: ld_value = raw_s;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the CPU data bus, stalls
// execute while a transaction is outstanding and registers the
// writeback-bound result. Non-memory instructions take one register stage.
// Ports:
//   clk, reset (async, active low)
//   in_*         : instruction from execute
//   stall        : hold execute
//   dreq_*       : bus request (registered)
//   dresp_*      : bus handshake / load data
//   out_*        : registered writeback record
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_dst,
    input  logic            in_wen,
    input  logic [3:0]      in_memop,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_result,
    output logic            stall,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_dst,
    output logic            out_wen,
    output logic [XLEN-1:0] out_result,
    output logic            out_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         dreq_valid_q, dreq_valid_d;
    logic [63:0]  req_addr_q, req_addr_d;
    logic [2:0]   req_size_q, req_size_d;
    logic [7:0]   req_strobe_q, req_strobe_d;
    logic [63:0]  req_data_q, req_data_d;
    mem_op_t      req_op_q, req_op_d;
    logic [63:0]  req_pc_q, req_pc_d;
    logic [4:0]   req_dst_q, req_dst_d;
    logic         req_wen_q, req_wen_d;
    memory_data_t out_q, out_d;

    mem_op_t      in_op_s;
    logic         in_misalign_s;
    logic         idle_accept_s;
    logic         complete_s;
    logic [7:0]   st_strobe_s;
    logic [63:0]  st_wdata_s;
    logic [63:0]  ld_value_s;

    // Store lanes come from the incoming instruction; load extraction
    // uses the latched request since in_* may already have moved on.
    mem_align u_align (
        .st_size   (memop_size(in_op_s)),
        .st_offset (in_addr[2:0]),
        .st_data   (in_result),
        .ld_op     (req_op_q),
        .ld_offset (req_addr_q[2:0]),
        .ld_data   (dresp_data),
        .st_strobe (st_strobe_s),
        .st_wdata  (st_wdata_s),
        .ld_value  (ld_value_s)
    );

    // Decode of the incoming instruction and the transaction handshake
    always_comb begin
        in_op_s       = mem_op_t'(in_memop);
        in_misalign_s = memop_misaligned(in_op_s, in_addr[2:0]);
        idle_accept_s = (state_q == S_IDLE) && in_valid
                        && memop_is_mem(in_op_s) && !in_misalign_s;
        complete_s    = ((state_q == S_REQ) && dresp_addr_ok && dresp_data_ok)
                        || ((state_q == S_WAIT) && dresp_data_ok);
        stall         = idle_accept_s
                        || (((state_q == S_REQ) || (state_q == S_WAIT)) && !complete_s);
    end

    // Next-state and next-register computation for the bus FSM
    always_comb begin
        state_d      = state_q;
        dreq_valid_d = dreq_valid_q;
        req_addr_d   = req_addr_q;
        req_size_d   = req_size_q;
        req_strobe_d = req_strobe_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;
        req_pc_d     = req_pc_q;
        req_dst_d    = req_dst_q;
        req_wen_d    = req_wen_q;
        out_d        = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!memop_is_mem(in_op_s)) begin
                        out_d.valid  = 1'b1;
                        out_d.pc     = in_pc;
                        out_d.dst    = in_dst;
                        out_d.wen    = in_wen;
                        out_d.result = in_result;
                    end else if (in_misalign_s) begin
                        out_d.valid    = 1'b1;
                        out_d.pc       = in_pc;
                        out_d.dst      = in_dst;
                        out_d.misalign = 1'b1;
                    end else begin
                        state_d      = S_REQ;
                        dreq_valid_d = 1'b1;
                        req_addr_d   = in_addr;
                        req_size_d   = memop_size(in_op_s);
                        // Loads never write memory regardless of lane math
                        req_strobe_d = memop_is_store(in_op_s) ? st_strobe_s : 8'h00;
                        req_data_d   = memop_is_store(in_op_s) ? st_wdata_s : 64'd0;
                        req_op_d     = in_op_s;
                        req_pc_d     = in_pc;
                        req_dst_d    = in_dst;
                        req_wen_d    = in_wen && !memop_is_store(in_op_s);
                    end
                end else begin
                    out_d = '0;
                end
            end
            S_REQ: begin
                if (dresp_addr_ok) begin
                    dreq_valid_d = 1'b0;
                    state_d      = dresp_data_ok ? S_IDLE : S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d      = S_IDLE;
                dreq_valid_d = 1'b0;
            end
        endcase
        if (complete_s) begin
            out_d.valid  = 1'b1;
            out_d.pc     = req_pc_q;
            out_d.dst    = req_dst_q;
            out_d.wen    = req_wen_q;
            out_d.result = memop_is_store(req_op_q) ? 64'd0 : ld_value_s;
        end else begin
            out_d.misalign = out_d.misalign;
        end
    end

    // State, request and writeback registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dreq_valid_q <= 1'b0;
            req_addr_q   <= 64'd0;
            req_size_q   <= 3'd0;
            req_strobe_q <= 8'd0;
            req_data_q   <= 64'd0;
            req_op_q     <= MEM_NONE;
            req_pc_q     <= 64'd0;
            req_dst_q    <= 5'd0;
            req_wen_q    <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            dreq_valid_q <= dreq_valid_d;
            req_addr_q   <= req_addr_d;
            req_size_q   <= req_size_d;
            req_strobe_q <= req_strobe_d;
            req_data_q   <= req_data_d;
            req_op_q     <= req_op_d;
            req_pc_q     <= req_pc_d;
            req_dst_q    <= req_dst_d;
            req_wen_q    <= req_wen_d;
            out_q        <= out_d;
        end
    end

    assign dreq_valid   = dreq_valid_q;
    assign dreq_addr    = req_addr_q;
    assign dreq_size    = req_size_q;
    assign dreq_strobe  = req_strobe_q;
    assign dreq_data    = req_data_q;
    assign out_valid    = out_q.valid;
    assign out_pc       = out_q.pc;
    assign out_dst      = out_q.dst;
    assign out_wen      = out_q.wen;
    assign out_result   = out_q.result;
    assign out_misalign = out_q.misalign;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute.
- Consumes execute's result, store data, memory address and control. Performs loads and stores over the CPU data bus. Registers the writeback-bound result.
- Stalls upstream while a bus transaction is in flight.
- Non-memory instructions pass through with one register stage of latency.

Parameters:
- XLEN, 64, datapath/address width (only 64 supported).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present (execute not bubble and not waiting)
- in_pc  in  64  instruction pc
- in_dst  in  5  destination register
- in_wen  in  1  writes register file
- in_memop  in  4  mem_op_t: MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
- in_addr  in  64  effective address
- in_result  in  64  ALU result, or store data for stores
- stall  out  1  hold upstream stage
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  request address (byte address, unmodified)
- dreq_size  out  3  log2 bytes: 0/1/2/3
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-aligned store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  access complete / load data valid
- dresp_data  in  64  8-byte-aligned load data
- out_valid  out  1  writeback-bound instruction valid
- out_pc  out  64  pc
- out_dst  out  5  destination register
- out_wen  out  1  register write enable
- out_result  out  64  final writeback value
- out_misalign  out  1  address misaligned; no access performed

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all out_* = 0.
  - dreq_valid=0; request registers = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - in_valid and memop≠NONE and aligned: latch addr/size/strobe/data/load-kind/pc/dst/wen into request regs; next state REQ; stall=1. out_valid=0 next edge.
  - in_valid and misaligned (LH/SH addr[0]≠0; LW/LWU/SW addr[1:0]≠0; LD/SD addr[2:0]≠0): no request. Next edge out_valid=1, out_misalign=1, out_wen=0; stall=0.
  - in_valid and memop=NONE: next edge out_* = in_*, out_result=in_result; stall=0.
  - in_valid=0: next edge out_valid=0.
- REQ:
  - dreq_valid=1; request fields driven from registers, stable until addr_ok.
  - addr_ok & data_ok same cycle → complete.
  - addr_ok only → WAIT.
  - neither → stay.
- WAIT:
  - dreq_valid=0.
  - data_ok → complete; else stay.
- Complete:
  - stall=0 in that cycle; next state IDLE.
  - Next edge out_valid=1, out_pc/dst/wen from request regs, out_result = load value (stores: out_wen=0, out_result=0).
- stall = (IDLE & in_valid & memop≠NONE & aligned) | ((REQ|WAIT) & ~data_ok).
- Non-completing cycles in REQ/WAIT: out_valid=0.
- Store encoding:
  - strobe = ({1,3,15,255} by size) << addr[2:0].
  - dreq_data = store data << (8*addr[2:0]).
- Load decoding:
  - raw = dresp_data >> (8*addr[2:0]).
  - LB/LH/LW: sign-extend bit 7/15/31; LBU/LHU/LWU: zero-extend; LD: raw.
- Latency: zero-wait bus (addr_ok&data_ok in first REQ cycle) → out_valid two edges after the instruction arrives. Each extra bus wait cycle adds one.
- data_ok while IDLE: ignored.
- Reset asserted mid-transaction: abandon immediately, return to IDLE. Responses arriving after reset release are ignored while IDLE.
- Upstream must hold in_* stable while stall=1. The stage re-reads in_* only in IDLE.

Decomposition:
- Shared pipes package:
  - mem_op_t enum.
  - memory_data_t struct bundling out_* fields.
  - MSIZE_B/H/W/D constants.
- One natural combinational sub-module, mem_align: strobe/data shifting and load extraction/extension.
- FSM and registers stay in memory_stage.

Test Plan:
- ALU pass-through: in_valid=1, memop=NONE, in_result=0x1234, dst=5 → next edge out_valid=1, out_result=0x1234, stall never asserted.
- SB at addr 0x…03, data 0xAB, zero-wait bus → dreq_strobe=0x08, dreq_data=0x00000000AB000000, size=0. out_valid 2 edges later, out_wen=0.
- LB at addr 0x…06, dresp_data=0x0080_0000_0000_0000 → out_result=0xFFFFFFFFFFFFFF80. The LBU variant gives 0x80.
- LW at 0x…04, addr_ok cycle 1, data_ok delayed 3 cycles (data 0x80000000_00000000) → stall high for all wait cycles, dreq_valid only in REQ, out_result=0xFFFFFFFF80000000.
- LD at addr 0x…04 (misaligned) → no dreq_valid, out_misalign=1, out_wen=0, stall=0.
- Reset pulsed low while in WAIT, then data_ok asserted after release → state IDLE, outputs 0, response ignored, no out_valid.
